alu_mc: RTL
===========

Name: alu_mc

Overview:
- Multi-cycle, handshaked successor to the single-cycle datapath ALU in the reduced RISC-V core.
- Width-parametrised. Extends the op set with xor, signed/unsigned compare, shifts, iterative multiply and iterative unsigned divide/remainder.
- Sits in the execute stage. The controller stalls on in_ready/out_valid instead of assuming one-cycle results.

Parameters:
- W, 32, operand/result width (>= 4, power of two).
- SHW, $clog2(W), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request (high only in IDLE).
- ALUctrl  input  4  operation select, sampled on accept.
- N1  input  W  operand A, sampled on accept.
- N2  input  W  operand B, sampled on accept.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer takes result.
- out  output  W  registered result.
- EQ  output  1  (out == 0), combinational from registered out.
- busy  output  1  high in BUSY.

Behaviour:
- Op codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or (all mod 2^W).
  - 0100 slt: signed compare, result 1/0.
  - 0101 sltu: unsigned compare, result 1/0. Code unchanged from previous ALU.
  - 0110 xor.
  - 0111 sll, 1000 srl, 1001 sra: shift amount = N2[SHW-1:0], upper N2 bits ignored.
  - 1010 mul: low W bits of unsigned product.
  - 1011 mulhu: high W bits of unsigned product.
  - 1100 divu, 1101 remu.
  - 1110/1111: see Optional Feature.
- FSM states IDLE, BUSY, DONE. Accept = in_valid && in_ready.
- IDLE:
  - On accept of a simple op (0000–1001): compute, register into out, go to DONE. out_valid is high in the next cycle (latency 1).
  - On accept of an iterative op: latch operands, load counter = W, go to BUSY.
- BUSY:
  - One step per cycle.
  - mul/mulhu: shift-add into a 2W accumulator.
  - divu/remu: restoring divide, one quotient bit per cycle.
  - Counter decrements each step. The step taken with counter == 1 writes out and goes to DONE.
  - Latency from accept edge to out_valid = W+1 cycles (33 at W=32).
- DONE:
  - out_valid = 1. out and EQ are stable.
  - On out_ready: go to IDLE. in_ready rises the following cycle, so there are no back-to-back accepts. Max simple-op throughput is one op per 2 cycles.
  - out holds its last value in IDLE until the next result.
- Divide by zero (divu): out = all ones. remu: out = N1. Still takes the full W+1 cycles, no exception.
- rst, sampled at any edge including mid-BUSY or in DONE:
  - State -> IDLE, counter = 0, accumulators = 0, out = 0.
  - Hence EQ = 1, out_valid = 0, busy = 0. in_ready = 1 on the first cycle after reset.
  - An in-flight result is discarded.
- in_valid asserted outside IDLE is ignored; the requester must hold it until in_ready.
- ALUctrl, N1 and N2 are don't-care outside the accept cycle.

Optional Feature:
- Macro ALU_MC_SIGNED_DIV_EN.
- Defined: 1110 = div (signed), 1111 = rem (signed), RISC-V semantics.
  - Operands are converted to magnitude, the unsigned core is reused, then the sign is fixed in the final step. Latency W+1.
  - Quotient truncates toward zero; remainder takes the sign of N1.
  - Divide by zero: div = all ones, rem = N1.
  - Overflow (N1 = most negative, N2 = -1): div = N1, rem = 0.
- Not defined: 1110/1111 decode as add (simple op, latency 1), matching the previous ALU's default. No sign logic is synthesised.

Test Plan:
- Reset mid-op: rst for 1 cycle after a mul accept, during BUSY -> next cycle out = 0, EQ = 1, busy = 0, in_ready = 1. No out_valid ever appears for the aborted op.
- Simple ops, out_ready tied 1:
  - sub 5-5 -> out = 0, EQ = 1, out_valid exactly 1 cycle after accept.
  - sltu 0xFFFFFFFF vs 1 -> 0; slt same operands -> 1.
  - sra 0x80000000 by N2 = 0x24 -> shift 4 -> 0xF8000000.
- Multiply: mul 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001; mulhu same -> 0xFFFFFFFE. out_valid rises exactly 33 cycles after accept; busy high 32 cycles.
- Divide: divu 100/7 -> 14, remu -> 2. divu 9/0 -> 0xFFFFFFFF, remu 9/0 -> 9.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out, out_valid stable, in_ready = 0, new in_valid ignored. Release -> in_ready = 1 next cycle.
- With ALU_MC_SIGNED_DIV_EN:
  - div -7/2 -> 0xFFFFFFFD, rem -> 0xFFFFFFFF.
  - div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0.
- Without the macro: 1110 with 3,4 -> 7 after 1 cycle.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle simple ops, iterative multiply and divide.
// Optional signed div/rem on codes 1110/1111 when ALU_MC_SIGNED_DIV_EN is defined.
module alu_mc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   ALUctrl,
  input  logic [W-1:0] N1,
  input  logic [W-1:0] N2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         EQ,
  output logic         busy
);
  localparam int SHW = $clog2(W);
  localparam logic [SHW:0] CNT_INIT = W[SHW:0];
  localparam logic [SHW:0] CNT_LAST = 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   a_reg, hi_reg, lo_reg, out_reg;
  logic [3:0]     op_reg;
  logic [SHW:0]   cnt_reg;
`ifdef ALU_MC_SIGNED_DIV_EN
  logic           negq_reg, negr_reg;
`endif

  function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_MC_SIGNED_DIV_EN
    return (op >= 4'b1010);
`else
    return (op >= 4'b1010) && (op <= 4'b1101);
`endif
  endfunction

  logic accept;
  assign accept = in_valid && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_iter(ALUctrl) ? BUSY : DONE;
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_reg == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [SHW-1:0] sh;
  logic [W-1:0]   simple_res;
  always_comb begin
    sh = N2[SHW-1:0];
    case (ALUctrl)
      4'b0001: simple_res = N1 - N2;
      4'b0010: simple_res = N1 & N2;
      4'b0011: simple_res = N1 | N2;
      4'b0100: simple_res = {{(W-1){1'b0}}, $signed(N1) < $signed(N2)};
      4'b0101: simple_res = {{(W-1){1'b0}}, N1 < N2};
      4'b0110: simple_res = N1 ^ N2;
      4'b0111: simple_res = N1 << sh;
      4'b1000: simple_res = N1 >> sh;
      4'b1001: simple_res = $signed(N1) >>> sh;
      default: simple_res = N1 + N2;
    endcase
  end

  // Multiply: hi:lo is the 2W accumulator with the multiplier shifting out of lo.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [W:0]   mul_sum, trial;
  logic [W-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, diff, hi_n, lo_n, final_res;
  logic         ge;
  always_comb begin
    mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
    mul_hi_n = mul_sum[W:1];
    mul_lo_n = {mul_sum[0], lo_reg[W-1:1]};
    trial    = {hi_reg, lo_reg[W-1]};
    ge       = (trial >= {1'b0, a_reg});
    diff     = trial[W-1:0] - a_reg;
    div_hi_n = ge ? diff : trial[W-1:0];
    div_lo_n = {lo_reg[W-2:0], ge};
    hi_n     = (op_reg[3:1] == 3'b101) ? mul_hi_n : div_hi_n;
    lo_n     = (op_reg[3:1] == 3'b101) ? mul_lo_n : div_lo_n;
    case (op_reg)
      4'b1010: final_res = mul_lo_n;
      4'b1011: final_res = mul_hi_n;
      4'b1100: final_res = div_lo_n;
      4'b1101: final_res = div_hi_n;
`ifdef ALU_MC_SIGNED_DIV_EN
      4'b1110: final_res = negq_reg ? -div_lo_n : div_lo_n;
      4'b1111: final_res = negr_reg ? -div_hi_n : div_hi_n;
`endif
      default: final_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      out_reg   <= '0;
      op_reg    <= '0;
      cnt_reg   <= '0;
`ifdef ALU_MC_SIGNED_DIV_EN
      negq_reg  <= 1'b0;
      negr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg <= ALUctrl;
        if (is_iter(ALUctrl)) begin
          a_reg   <= N2;
          lo_reg  <= N1;
          hi_reg  <= '0;
          cnt_reg <= CNT_INIT;
`ifdef ALU_MC_SIGNED_DIV_EN
          // Signed ops run the unsigned core on magnitudes; signs are reapplied at the end.
          negq_reg <= (N1[W-1] ^ N2[W-1]) && (N2 != '0);
          negr_reg <= N1[W-1];
          if (ALUctrl[3:1] == 3'b111) begin
            a_reg  <= N2[W-1] ? -N2 : N2;
            lo_reg <= N1[W-1] ? -N1 : N1;
          end
`endif
        end else begin
          out_reg <= simple_res;
        end
      end else if (state_reg == BUSY) begin
        hi_reg  <= hi_n;
        lo_reg  <= lo_n;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_LAST) out_reg <= final_res;
      end
    end
  end

  assign out = out_reg;
  assign EQ  = (out_reg == '0);
endmodule
